sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
Shares one single-port SRAM between the instruction-fetch (I) and data-access (D) sides of the RISC-V core, so a unified memory can replace the separate I/D memories. It performs at most one SRAM access per cycle and returns read data one cycle after the grant, matching the synchronous-read SRAM timing. D-side requests win by default. A starvation counter guarantees the I side a grant after a bounded wait.

Parameters:
AWIDTH, 12, SRAM word/byte address width passed to MEM_ADDR.
MAX_WAIT, 4, consecutive denied I-side cycles before the I side takes priority; legal range 1..15.

Ports:
CLK  in  1  clock
RSTn  in  1  reset, synchronous, active-low
I_REQ  in  1  fetch request; held until I_GNT
I_ADDR  in  AWIDTH  fetch address
I_GNT  out  1  fetch accepted this cycle (combinational)
I_RVALID  out  1  fetch data valid (cycle after I_GNT)
I_RDATA  out  32  fetch data
D_REQ  in  1  data request; held until D_GNT
D_WE  in  1  1 = write, 0 = read
D_ADDR  in  AWIDTH  data address
D_BE  in  4  byte enables for writes
D_WDATA  in  32  write data
D_GNT  out  1  data access accepted this cycle (combinational)
D_RVALID  out  1  data access completed (cycle after D_GNT; reads and writes)
D_RDATA  out  32  read data; 0 for completed writes
MEM_CSN  out  1  SRAM chip select, active-low
MEM_WEN  out  1  SRAM write enable, active-low
MEM_ADDR  out  AWIDTH  SRAM address
MEM_BE  out  4  SRAM byte enables
MEM_DI  out  32  SRAM write data
MEM_DOUT  in  32  SRAM read data, valid the cycle after access

Behaviour:
- State registers:
  - starve_cnt (4b).
  - rsp_i: I response pending.
  - rsp_d: D response pending.
  - rsp_d_rd: pending D response is a read.
- Arbitration (combinational; all grants forced to 0 while RSTn=0):
  - Only I_REQ: I_GNT=1.
  - Only D_REQ: D_GNT=1.
  - Both requesting: D_GNT=1, unless starve_cnt==MAX_WAIT, in which case I_GNT=1.
  - Never both grants in one cycle.
- starve_cnt, updated at posedge:
  - I_REQ & ~I_GNT: increment, saturating at MAX_WAIT.
  - Otherwise (I_GNT or ~I_REQ): clear to 0.
- SRAM drive (combinational):
  - MEM_CSN = ~(I_GNT | D_GNT).
  - MEM_WEN = ~(D_GNT & D_WE).
  - MEM_ADDR = D_ADDR if D_GNT, I_ADDR if I_GNT, else 0.
  - MEM_BE = D_BE if D_GNT, else 4'b0000.
  - MEM_DI = D_WDATA if D_GNT & D_WE, else 0.
- Response pipeline (registered, 1-cycle latency):
  - rsp_i <= I_GNT.
  - rsp_d <= D_GNT.
  - rsp_d_rd <= D_GNT & ~D_WE.
  - I_RVALID = rsp_i; I_RDATA = rsp_i ? MEM_DOUT : 0.
  - D_RVALID = rsp_d; D_RDATA = rsp_d_rd ? MEM_DOUT : 0.
- Throughput: back-to-back grants every cycle. A response and a new grant may coexist in the same cycle, to the same or the other requester.
- Requester rule: the requester keeps REQ and its address/data stable until GNT. The arbiter does not latch request fields.
- Reset: RSTn low at a posedge clears starve_cnt, rsp_i, rsp_d and rsp_d_rd to 0. Resulting output values:
  - GNTs 0, RVALIDs 0, RDATAs 0.
  - MEM_CSN=1, MEM_WEN=1, MEM_BE=0.
  - MEM_ADDR=0, MEM_DI=0.
- Reset mid-operation: a response pending at reset is dropped (no RVALID). An access granted in the cycle RSTn falls is suppressed because grants are gated.
- MAX_WAIT=1: under continuous contention, grants alternate D, I, D, I.

Test Plan:
- Reset: hold RSTn=0 for 3 cycles with I_REQ=D_REQ=1 -> GNTs 0, MEM_CSN=1, MEM_WEN=1, RVALIDs 0 throughout; starve_cnt 0 after release.
- Solo fetch: preload word 0x00500093 at addr 0x010; I_REQ=1, I_ADDR=0x010 for 1 cycle -> I_GNT=1 that cycle, MEM_CSN=0; next cycle I_RVALID=1, I_RDATA=0x00500093.
- Write then read: D write addr 0x100, D_BE=4'b0011, D_WDATA=0xAABBCCDD over prior 0x11223344 -> MEM_WEN=0, D_RVALID next cycle, D_RDATA=0. Then a D read of 0x100 -> D_RDATA=0x1122CCDD.
- Contention, MAX_WAIT=4: D_REQ and I_REQ held high from cycle 0 -> D_GNT cycles 0-3, I_GNT cycle 4, D_GNT cycle 5; starve_cnt 1,2,3,4,0,1.
- Interleave: I granted cycle n, D read granted cycle n+1 -> I_RVALID cycle n+1, D_RVALID cycle n+2, each with its own correct data, no crossover.
- Reset mid-operation: D read granted, RSTn=0 the next cycle -> D_RVALID stays 0, D_RDATA=0.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one synchronous-read single-port SRAM between the
// instruction-fetch and data sides, with D priority and a bounded I-side wait.
`default_nettype none

module sram_port_arbiter #(
  parameter int AWIDTH   = 12,
  parameter int MAX_WAIT = 4
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              I_REQ,
  input  logic [AWIDTH-1:0] I_ADDR,
  output logic              I_GNT,
  output logic              I_RVALID,
  output logic [31:0]       I_RDATA,
  input  logic              D_REQ,
  input  logic              D_WE,
  input  logic [AWIDTH-1:0] D_ADDR,
  input  logic [3:0]        D_BE,
  input  logic [31:0]       D_WDATA,
  output logic              D_GNT,
  output logic              D_RVALID,
  output logic [31:0]       D_RDATA,
  output logic              MEM_CSN,
  output logic              MEM_WEN,
  output logic [AWIDTH-1:0] MEM_ADDR,
  output logic [3:0]        MEM_BE,
  output logic [31:0]       MEM_DI,
  input  logic [31:0]       MEM_DOUT
);

  localparam logic [3:0] C_MAX_WAIT = 4'(MAX_WAIT);

  logic [3:0] r_starve_cnt;
  logic       r_rsp_i;
  logic       r_rsp_d;
  logic       r_rsp_d_rd;
  logic       w_starved;

  assign w_starved = (r_starve_cnt == C_MAX_WAIT);

  // D wins contention unless the I side has waited MAX_WAIT cycles.
  assign I_GNT = RSTn & I_REQ & (~D_REQ | w_starved);
  assign D_GNT = RSTn & D_REQ & ~I_GNT;

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_starve_cnt <= 4'd0;
      r_rsp_i      <= 1'b0;
      r_rsp_d      <= 1'b0;
      r_rsp_d_rd   <= 1'b0;
    end else begin
      r_rsp_i    <= I_GNT;
      r_rsp_d    <= D_GNT;
      r_rsp_d_rd <= D_GNT & ~D_WE;
      if (I_REQ && !I_GNT) begin
        if (!w_starved) begin
          r_starve_cnt <= r_starve_cnt + 4'd1;
        end
      end else begin
        r_starve_cnt <= 4'd0;
      end
    end
  end

  assign MEM_CSN  = ~(I_GNT | D_GNT);
  assign MEM_WEN  = ~(D_GNT & D_WE);
  assign MEM_ADDR = D_GNT ? D_ADDR : (I_GNT ? I_ADDR : '0);
  assign MEM_BE   = D_GNT ? D_BE : 4'b0000;
  assign MEM_DI   = (D_GNT && D_WE) ? D_WDATA : 32'h0;

  // Responses are masked while reset is held so a pending one is dropped.
  assign I_RVALID = RSTn & r_rsp_i;
  assign I_RDATA  = (RSTn && r_rsp_i) ? MEM_DOUT : 32'h0;
  assign D_RVALID = RSTn & r_rsp_d;
  assign D_RDATA  = (RSTn && r_rsp_d_rd) ? MEM_DOUT : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed plus random stimulus against a transaction-level
// model of the arbiter and a behavioural synchronous-read SRAM.
`default_nettype none

module tb_sram_port_arbiter;

  localparam int AW   = 12;
  localparam int MAXW = 4;

  logic          CLK = 1'b0;
  logic          RSTn;
  logic          I_REQ, D_REQ, D_WE;
  logic [AW-1:0] I_ADDR, D_ADDR;
  logic [3:0]    D_BE;
  logic [31:0]   D_WDATA;
  logic          I_GNT, I_RVALID, D_GNT, D_RVALID;
  logic [31:0]   I_RDATA, D_RDATA;
  logic          MEM_CSN, MEM_WEN;
  logic [AW-1:0] MEM_ADDR;
  logic [3:0]    MEM_BE;
  logic [31:0]   MEM_DI;
  logic [31:0]   MEM_DOUT = 32'h0;

  sram_port_arbiter #(.AWIDTH(AW), .MAX_WAIT(MAXW)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_GNT(I_GNT), .I_RVALID(I_RVALID), .I_RDATA(I_RDATA),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_BE(D_BE), .D_WDATA(D_WDATA),
    .D_GNT(D_GNT), .D_RVALID(D_RVALID), .D_RDATA(D_RDATA),
    .MEM_CSN(MEM_CSN), .MEM_WEN(MEM_WEN), .MEM_ADDR(MEM_ADDR), .MEM_BE(MEM_BE),
    .MEM_DI(MEM_DI), .MEM_DOUT(MEM_DOUT)
  );

  always #5 CLK = ~CLK;

  // Behavioural SRAM driven only by the DUT's memory port.
  logic [31:0] sram [0:(1<<AW)-1];
  always @(posedge CLK) begin
    if (!MEM_CSN) begin
      if (!MEM_WEN) begin
        for (int b = 0; b < 4; b++)
          if (MEM_BE[b]) sram[MEM_ADDR][8*b +: 8] <= MEM_DI[8*b +: 8];
      end else begin
        MEM_DOUT <= sram[MEM_ADDR];
      end
    end
  end

  // Reference model state: memory contents, denied-cycle count, expected responses.
  logic [31:0] shadow [0:(1<<AW)-1];
  int          wcnt;
  logic        pi_v, pd_v;
  logic [31:0] pi_d, pd_d;
  logic        cap_ig, cap_dg, cap_iv, cap_dv;
  logic [31:0] cap_id, cap_dd;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check every output against the model, advance model.
  task automatic step(input logic rn, input logic ireq, input logic [AW-1:0] ia,
                      input logic dreq, input logic dwe, input logic [AW-1:0] da,
                      input logic [3:0] be, input logic [31:0] wd);
    logic eig, edg;
    RSTn = rn; I_REQ = ireq; I_ADDR = ia;
    D_REQ = dreq; D_WE = dwe; D_ADDR = da; D_BE = be; D_WDATA = wd;
    #1;
    eig = rn && ireq && (!dreq || wcnt >= MAXW);
    edg = rn && dreq && !eig;
    chk("i_gnt",    I_GNT,    eig);
    chk("d_gnt",    D_GNT,    edg);
    chk("mem_csn",  MEM_CSN,  !(eig || edg));
    chk("mem_wen",  MEM_WEN,  !(edg && dwe));
    chk("mem_addr", MEM_ADDR, edg ? da : (eig ? ia : '0));
    chk("mem_be",   MEM_BE,   edg ? be : 4'b0);
    chk("mem_di",   MEM_DI,   (edg && dwe) ? wd : 32'h0);
    chk("i_rvalid", I_RVALID, rn && pi_v);
    chk("i_rdata",  I_RDATA,  (rn && pi_v) ? pi_d : 32'h0);
    chk("d_rvalid", D_RVALID, rn && pd_v);
    chk("d_rdata",  D_RDATA,  (rn && pd_v) ? pd_d : 32'h0);
    cap_ig = I_GNT; cap_dg = D_GNT; cap_iv = I_RVALID; cap_dv = D_RVALID;
    cap_id = I_RDATA; cap_dd = D_RDATA;
    pi_v = eig;
    pi_d = shadow[ia];
    pd_v = edg;
    pd_d = (edg && !dwe) ? shadow[da] : 32'h0;
    if (edg && dwe)
      for (int b = 0; b < 4; b++)
        if (be[b]) shadow[da][8*b +: 8] = wd[8*b +: 8];
    if (!rn || !ireq || eig) wcnt = 0;
    else if (wcnt < MAXW) wcnt = wcnt + 1;
    @(posedge CLK);
    #1;
  endtask

  logic [1:0]    pat [0:5];
  logic          ip, dp, rdwe;
  logic [AW-1:0] ria, rda;
  logic [3:0]    rbe;
  logic [31:0]   rwd;

  initial begin
    for (int a = 0; a < (1<<AW); a++) begin
      sram[a]   = $urandom;
      shadow[a] = sram[a];
    end
    sram[12'h010] = 32'h00500093; shadow[12'h010] = 32'h00500093;
    sram[12'h100] = 32'h11223344; shadow[12'h100] = 32'h11223344;
    wcnt = 0; pi_v = 0; pd_v = 0; pi_d = 0; pd_d = 0;
    RSTn = 0; I_REQ = 0; D_REQ = 0; D_WE = 0; I_ADDR = 0; D_ADDR = 0; D_BE = 0; D_WDATA = 0;
    @(posedge CLK); #1;

    // Reset held with both sides requesting.
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 12'h020, 1, 0, 12'h030, 4'hF, 32'h0);
      chk("rst_gnts", {cap_ig, cap_dg, cap_iv, cap_dv}, 4'b0000);
    end

    // Contention right after release: count starts at 0.
    pat[0] = 2'b01; pat[1] = 2'b01; pat[2] = 2'b01;
    pat[3] = 2'b01; pat[4] = 2'b10; pat[5] = 2'b01;
    for (int k = 0; k < 6; k++) begin
      step(1, 1, 12'h020, 1, 0, 12'h030, 4'hF, 32'h0);
      chk("contention", {cap_ig, cap_dg}, pat[k]);
    end
    step(1, 0, 0, 0, 0, 0, 0, 0);

    // Solo fetch.
    step(1, 1, 12'h010, 0, 0, 0, 0, 0);
    chk("fetch_gnt", cap_ig, 1'b1);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("fetch_data", {31'h0, cap_iv} ^ cap_id, 32'h00500092);

    // Byte-enabled write then read-back.
    step(1, 0, 0, 1, 1, 12'h100, 4'b0011, 32'hAABBCCDD);
    step(1, 0, 0, 1, 0, 12'h100, 4'b0000, 32'h0);
    chk("wr_rsp", {cap_dv, cap_dd}, {1'b1, 32'h0});
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rd_data", cap_dd, 32'h1122CCDD);

    // Interleave: I then D read, responses do not cross.
    step(1, 1, 12'h010, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 12'h100, 4'hF, 32'h0);
    chk("ilv_i", {cap_iv, cap_dv, cap_id}, {2'b10, 32'h00500093});
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("ilv_d", {cap_iv, cap_dv, cap_dd}, {2'b01, 32'h1122CCDD});

    // Reset right after a D read grant drops the response.
    step(1, 0, 0, 1, 0, 12'h100, 4'hF, 32'h0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_drop", {cap_dv, cap_dd}, 33'h0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_drop2", {cap_dv, cap_dd}, 33'h0);

    // Random traffic; requesters hold fields until granted.
    ip = 0; dp = 0; ria = 0; rda = 0; rdwe = 0; rbe = 0; rwd = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!ip && ($urandom_range(0, 3) != 0)) begin
        ip = 1; ria = 12'($urandom_range(0, 63));
      end
      if (!dp && ($urandom_range(0, 2) != 0)) begin
        dp = 1; rda = 12'($urandom_range(0, 63)); rdwe = 1'($urandom);
        rbe = 4'($urandom); rwd = $urandom;
      end
      step(($urandom_range(0, 99) != 0), ip, ria, dp, rdwe, rda, rbe, rwd);
      if (cap_ig) ip = 0;
      if (cap_dg) dp = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
